// File: rtl/rom_rd_ctrl.sv
// rom_rd_ctrl: burst read initiator for the 64x16 ROM.
// Credit-limited capture FIFO feeds a valid/ready consumer.
module rom_rd_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              rom_read,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  popped_q, popped_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend1_q, pend1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic              issue_ok;
  logic [CW:0]       credit;
  logic [LEN_W-1:0]  issued_inc;
  logic [LEN_W-1:0]  popped_inc;

  assign push       = pend1_q;
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  assign out_data   = out_valid ? mem_q[rptr_q] : '0;
  assign issued_inc = issued_q + LEN_W'(1);
  assign popped_inc = popped_q + LEN_W'(1);

  // Words buffered plus words still in the ROM pipe must fit the FIFO.
  assign credit = {1'b0, count_q}
                + (CW+1)'(rd_q)
                + (CW+1)'(pend1_q);

  assign issue_ok = (state_q == S_FETCH)
                 && (issued_q < len_q)
                 && (credit < (CW+1)'(FIFO_DEPTH));

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_read = rd_q;
  assign rom_addr = addr_q;

  // Next-state: command accept, read issue, FIFO pointers, completion.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    pend1_d  = rd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wptr_d   = wptr_q + PW'(push);
    rptr_d   = rptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            base_d   = base_addr;
            len_d    = burst_len;
            issued_d = '0;
            popped_d = '0;
            busy_d   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (issue_ok) begin
          rd_d     = 1'b1;
          addr_d   = base_q + ADDR_W'(issued_q);
          issued_d = issued_inc;
          if (issued_inc == len_q) state_d = S_DRAIN;
        end
        if (pop) popped_d = popped_inc;
      end
      S_DRAIN: begin
        if (pop) begin
          popped_d = popped_inc;
          if (popped_inc == len_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and pointer registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      pend1_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      pend1_q  <= pend1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; emptiness is tracked by count_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= rom_dout;
  end

endmodule

// File: doc/rom_rd_ctrl.md
# rom_rd_ctrl

Read-side initiator for the 64x16 weight/ifmap `rom`. On a `start` command it issues a burst of consecutive `read`/`addr` requests to the ROM, captures the returned `dout` words, and streams them to the PE-array loader over a valid/ready interface. It handles ROM read latency, downstream backpressure through a small credit-limited FIFO, and address wrap-around. It replaces hand-sequenced address generation with a reusable hardware block.

## Interface
Parameters:
- ADDR_W, 6, ROM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, ROM word width.
- LEN_W, 4, burst length field width; maximum burst is 2^LEN_W-1.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- start  in  1  command strobe; accepted only while busy=0.
- base_addr  in  ADDR_W  first ROM address of the burst; sampled with start.
- burst_len  in  LEN_W  number of words; sampled with start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- rom_read  out  1  ROM read enable; registered.
- rom_addr  out  ADDR_W  ROM address; registered.
- rom_dout  in  DATA_W  ROM data, valid one cycle after the ROM samples read=1.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: on start=1 with burst_len>0, latch base_addr and burst_len, clear the issued and popped counters, set busy=1, and go to FETCH. On start=1 with burst_len=0, pulse done on the next cycle, keep busy=0, and issue no read.
- start is ignored while busy=1, including its base_addr and burst_len.
- FETCH issue rule, evaluated every edge:
  - Condition: issued < len and fifo_count + rom_read + pend1 < FIFO_DEPTH, with all terms at their current register values.
  - If the condition holds, rom_read<=1, rom_addr<=base+issued (mod 2^ADDR_W), and issued increments.
  - Otherwise rom_read<=0 and rom_addr holds its value.
  - When the last word is issued, go to DRAIN.
- Capture pipeline:
  - pend1<=rom_read each edge.
  - When pend1=1, rom_dout is pushed into the FIFO at the next edge.
  - The credit rule guarantees a push never hits a full FIFO. A push and a pop in the same edge are both performed.
- DRAIN: rom_read<=0. At the edge where the final word (popped = len) is popped, go to IDLE, set busy<=0 and done<=1.
- done is 1 for exactly one cycle. start may be accepted in the cycle done is high.
- The FIFO is strictly in order: no drops and no duplicates under any out_ready pattern.
- Reset (asynchronous, any time):
  - rom_read=0, rom_addr=0, busy=0, done=0, out_valid=0, out_data=0.
  - FIFO is emptied, pend1=0, state=IDLE.
  - In-flight ROM data is discarded.

## Timing
- start sampled at edge T0:
  - rom_read=1 and rom_addr=base after T1.
  - ROM samples the request at T2.
  - Word pushed into the FIFO at T3; out_valid=1 after T3.
- With out_ready held high, one word is issued and one delivered per cycle, with no bubbles.
- For a burst of N words with constant ready, done is high in the cycle after edge T0+N+3.
- While the consumer stalls, reads stop once fifo_count plus in-flight reads reaches FIFO_DEPTH. Issuing resumes the edge after the credit condition holds again.
- Address wrap example: base=62, len=4 gives rom_addr 62, 63, 0, 1.

## Test plan
- Reset: assert rst mid-cycle, asynchronously, with no clock edge. Required: all outputs 0 immediately, state IDLE.
- Basic burst: base=0, len=7, out_ready=1. Required: rom_addr 0..6 on 7 consecutive cycles, out_data = ROM[0..6] in order, first out_valid 3 cycles after start, done pulses once, busy=0 afterwards.
- Backpressure: base=55, len=5, out_ready=0 for 8 cycles after start, then 1. Required:
  - rom_read stops after 4 issues.
  - out_data holds ROM[55] with out_valid=1 during the stall.
  - After release, ROM[55..59] delivered in order, followed by a single done pulse.
- Wrap and degenerate cases:
  - base=62, len=4 gives rom_addr 62, 63, 0, 1.
  - len=0 gives a done pulse one cycle after start, with no rom_read.
  - start asserted while busy is ignored, and the active burst is unaffected.
- Back-to-back commands: start base=7, len=7; then assert start with base=52, len=5 in the done cycle. Required: ROM[7..13] then ROM[52..56], with exactly one done pulse per burst.
- Reset mid-burst: base=21, len=9, assert rst after 3 words are delivered. Required: out_valid=0 immediately. A fresh start with base=28, len=9 then yields exactly ROM[28..36] with no stale words.
